// File: rtl/cail_param_store_if.sv
// Request/result bus toward the calibration logic plus the byte-command bus toward the IIC master.
// The slave modport is the parameter store's view; master is the surrounding environment's view.
interface cail_param_store_if #(
   parameter int CH_W       = 4,
   parameter int TYPE_W     = 2,
   parameter int DATA_BYTES = 4,
   parameter int ADDR_W     = 16
);
   localparam int DW = 8 * DATA_BYTES;

   logic              wr_req;
   logic              rd_req;
   logic [CH_W-1:0]   ch;
   logic [TYPE_W-1:0] ptype;
   logic              mult;
   logic [DW-1:0]     in_data;
   logic [DW-1:0]     result;
   logic              result_valid;
   logic              busy;
   logic              ovf;
   logic              range_err;
   logic              ack_err;

   logic              i2c_start;
   logic              i2c_wr;
   logic [6:0]        i2c_dev;
   logic [ADDR_W-1:0] i2c_addr;
   logic [7:0]        i2c_wdata;
   logic [7:0]        i2c_rdata;
   logic              i2c_done;
   logic              i2c_ack_err;

   modport master (
      output wr_req, rd_req, ch, ptype, mult, in_data,
      input  result, result_valid, busy, ovf, range_err, ack_err,
      input  i2c_start, i2c_wr, i2c_dev, i2c_addr, i2c_wdata,
      output i2c_rdata, i2c_done, i2c_ack_err
   );

   modport slave (
      input  wr_req, rd_req, ch, ptype, mult, in_data,
      output result, result_valid, busy, ovf, range_err, ack_err,
      output i2c_start, i2c_wr, i2c_dev, i2c_addr, i2c_wdata,
      input  i2c_rdata, i2c_done, i2c_ack_err
   );
endinterface

// File: rtl/cail_param_store.sv
// Calibration-parameter store: queues {ch,type,mult} read/write requests and runs each as byte commands
// to the IIC master; first i2c_start 3 clocks after a request into an idle block, requests dropped (ovf) when the queue is full.
module cail_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_vld,
   input  logic [W-1:0] in_dat,
   output logic         full,
   input  logic         out_rdy,
   output logic [W-1:0] out_dat,
   output logic         empty
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          push;
   logic          pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign push    = in_vld & ~full;
   assign pop     = out_rdy & ~empty;
   assign out_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_dat;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

module cail_param_store #(
   parameter int         CH_NUM     = 16,
   parameter int         CH_W       = 4,
   parameter int         TYPE_NUM   = 4,
   parameter int         TYPE_W     = 2,
   parameter int         DATA_BYTES = 4,
   parameter int         ADDR_W     = 16,
   parameter int         BASE_ADDR  = 0,
   parameter logic [6:0] DEV_ADDR   = 7'h50,
   parameter int         FIFO_DEPTH = 4,
   parameter int         TWR_CYC    = 250000
) (
   input logic               clk,
   input logic               rst,
   cail_param_store_if.slave bus
);
   localparam int DW = 8 * DATA_BYTES;
   localparam int KW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
   localparam int CW = $clog2(TWR_CYC + 1);

   typedef struct packed {
      logic              do_wr;
      logic              do_rd;
      logic [CH_W-1:0]   ch;
      logic [TYPE_W-1:0] ptype;
      logic              mult;
      logic [DW-1:0]     data;
   } entry_t;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_WR_CMD, S_WR_WAIT, S_WR_DLY, S_RD_CMD, S_RD_WAIT, S_FIN
   } state_t;

   state_t            state, state_nxt;
   entry_t            req_ent, head_ent, work;
   logic              req, in_range, q_full, q_empty, pop;
   logic [ADDR_W-1:0] key_addr, addr_base;
   logic [KW-1:0]     k;
   logic [CW-1:0]     dly_cnt;
   logic              dly_last, last_byte;
   logic [DW-1:0]     shadow;
   logic              start_c, wr_c, ack_set;

   // A same-cycle wr+rd becomes one WRRD entry so the write is guaranteed to land before the read.
   assign req      = bus.wr_req | bus.rd_req;
   assign in_range = (32'(bus.ch) < 32'(CH_NUM));
   assign req_ent  = '{do_wr: bus.wr_req, do_rd: bus.rd_req, ch: bus.ch, ptype: bus.ptype,
                       mult: bus.mult, data: bus.in_data};
   assign pop      = (state == S_IDLE) & ~q_empty;

   cail_fifo #(.W($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_req_fifo (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (req & in_range),
      .in_dat  (req_ent),
      .full    (q_full),
      .out_rdy (pop),
      .out_dat (head_ent),
      .empty   (q_empty)
   );

   assign key_addr  = ADDR_W'(32'(BASE_ADDR) +
                      ((32'(work.ch) * 32'(TYPE_NUM) + 32'(work.ptype)) * 32'd2 + 32'(work.mult)) *
                      32'(DATA_BYTES));
   assign last_byte = (k == KW'(DATA_BYTES - 1));
   assign dly_last  = (dly_cnt == CW'(TWR_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start_c   = 1'b0;
      wr_c      = 1'b0;
      ack_set   = 1'b0;
      case (state)
         S_IDLE:    if (!q_empty) state_nxt = S_LOAD;
         S_LOAD:    state_nxt = work.do_wr ? S_WR_CMD : S_RD_CMD;
         S_WR_CMD: begin
            start_c   = 1'b1;
            wr_c      = 1'b1;
            state_nxt = S_WR_WAIT;
         end
         S_WR_WAIT: begin
            wr_c = 1'b1;
            if (bus.i2c_done) begin
               ack_set   = bus.i2c_ack_err;
               state_nxt = bus.i2c_ack_err ? S_IDLE : S_WR_DLY;
            end
         end
         S_WR_DLY: begin
            if (dly_last) begin
               if (!last_byte)       state_nxt = S_WR_CMD;
               else if (work.do_rd)  state_nxt = S_RD_CMD;
               else                  state_nxt = S_FIN;
            end
         end
         S_RD_CMD: begin
            start_c   = 1'b1;
            state_nxt = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (bus.i2c_done) begin
               ack_set = bus.i2c_ack_err;
               if (bus.i2c_ack_err) state_nxt = S_IDLE;
               else if (last_byte)  state_nxt = S_FIN;
               else                 state_nxt = S_RD_CMD;
            end
         end
         S_FIN:     state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         work             <= '0;
         addr_base        <= '0;
         k                <= '0;
         dly_cnt          <= '0;
         shadow           <= '0;
         bus.result       <= '0;
         bus.result_valid <= 1'b0;
         bus.ack_err      <= 1'b0;
         bus.ovf          <= 1'b0;
         bus.range_err    <= 1'b0;
      end else begin
         bus.result_valid <= 1'b0;
         bus.ack_err      <= ack_set;
         // Fullness is judged before this cycle's pop, so a pop never rescues a request.
         bus.ovf          <= req & in_range & q_full;
         bus.range_err    <= req & ~in_range;
         case (state)
            S_IDLE:    if (!q_empty) work <= head_ent;
            S_LOAD: begin
               addr_base <= key_addr;
               k         <= '0;
            end
            S_WR_WAIT: dly_cnt <= '0;
            S_WR_DLY: begin
               if (dly_last) begin
                  dly_cnt <= '0;
                  k       <= last_byte ? '0 : k + 1'b1;
               end else begin
                  dly_cnt <= dly_cnt + 1'b1;
               end
            end
            S_RD_WAIT: begin
               if (bus.i2c_done && !bus.i2c_ack_err) begin
                  shadow[{k, 3'b000} +: 8] <= bus.i2c_rdata;
                  if (!last_byte) k <= k + 1'b1;
               end
            end
            S_FIN: begin
               if (work.do_rd) begin
                  bus.result       <= shadow;
                  bus.result_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Address, direction and data derive from registers that only move outside the command/wait window.
   assign bus.i2c_start = start_c;
   assign bus.i2c_wr    = wr_c;
   assign bus.i2c_dev   = DEV_ADDR;
   assign bus.i2c_addr  = addr_base + ADDR_W'(k);
   assign bus.i2c_wdata = work.data[{k, 3'b000} +: 8];
   assign bus.busy      = ~q_empty | (state != S_IDLE);
endmodule

// File: tb/tb_cail_param_store.sv
// Scoreboard bench: stimulus queues expected IIC commands and results; a monitor checks them as they appear.
module tb_cail_param_store;
   localparam int CH_W = 5;
   localparam int TWR  = 50;

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [7:0]  wdata;
   } cmd_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cail_param_store_if #(.CH_W(CH_W)) bus ();
   cail_param_store #(.CH_W(CH_W), .TWR_CYC(TWR)) dut (.clk(clk), .rst(rst), .bus(bus));

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   cmd_t        exp_cmd[$];
   logic [31:0] exp_res[$];
   logic [7:0]  mem [0:1023];
   int          n_rv = 0, n_ovf = 0, n_rng = 0, n_ack = 0;
   logic        nack_arm = 1'b0;
   logic [15:0] nack_addr = '0;
   int          last_wr_done = 0;
   bit          wr_gap_chk = 0;
   bit          lat_arm = 0;
   int          req_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic preload(input int a, input logic [31:0] d);
      for (int i = 0; i < 4; i++) mem[a + i] = d[8*i +: 8];
   endtask

   task automatic exp_wr(input logic [15:0] a, input logic [31:0] d);
      for (int i = 0; i < 4; i++) exp_cmd.push_back('{wr: 1'b1, addr: a + 16'(i), wdata: d[8*i +: 8]});
   endtask

   task automatic exp_rd(input logic [15:0] a, input int n);
      for (int i = 0; i < n; i++) exp_cmd.push_back('{wr: 1'b0, addr: a + 16'(i), wdata: 8'h00});
   endtask

   task automatic set_req(input logic w, input logic r, input logic [4:0] c, input logic [1:0] t,
                          input logic m, input logic [31:0] d);
      bus.wr_req = w; bus.rd_req = r; bus.ch = c; bus.ptype = t; bus.mult = m; bus.in_data = d;
   endtask

   task automatic req(input logic w, input logic r, input logic [4:0] c, input logic [1:0] t,
                      input logic m, input logic [31:0] d);
      @(posedge clk); #1;
      set_req(w, r, c, t, m, d);
      req_cyc = cyc;
      @(posedge clk); #1;
      bus.wr_req = 1'b0; bus.rd_req = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int quiet = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!bus.busy && exp_cmd.size() == 0 && exp_res.size() == 0) quiet++;
         else quiet = 0;
         if (quiet >= 3) return;
      end
      total++; bad++;
      $display("FAIL timeout_%s: busy=%0b cmds_left=%0d results_left=%0d, want all idle",
               name, bus.busy, exp_cmd.size(), exp_res.size());
   endtask

   // IIC master/EEPROM model: done 20 clocks after start, optional single NACK at nack_addr.
   initial begin : iic_model
      logic        m_w;
      logic [15:0] m_a;
      logic [7:0]  m_d;
      logic        m_nack;
      bus.i2c_done = 1'b0; bus.i2c_ack_err = 1'b0; bus.i2c_rdata = 8'h00;
      forever begin
         @(negedge clk);
         bus.i2c_done = 1'b0; bus.i2c_ack_err = 1'b0;
         if (bus.i2c_start) begin
            m_w = bus.i2c_wr; m_a = bus.i2c_addr; m_d = bus.i2c_wdata;
            repeat (19) @(negedge clk);
            check("hold_addr", 32'(bus.i2c_addr), 32'(m_a));
            check("hold_wr", 32'(bus.i2c_wr), 32'(m_w));
            m_nack = nack_arm && (m_a == nack_addr);
            if (m_nack) nack_arm = 1'b0;
            if (m_w && !m_nack) mem[m_a[9:0]] = m_d;
            bus.i2c_rdata   = mem[m_a[9:0]];
            bus.i2c_ack_err = m_nack;
            bus.i2c_done    = 1'b1;
            if (m_w) begin
               last_wr_done = cyc;
               wr_gap_chk   = 1;
            end
         end
      end
   end

   initial begin : monitor
      cmd_t e;
      forever begin
         @(negedge clk);
         if (bus.i2c_start) begin
            if (lat_arm) begin
               check("start_latency", 32'(cyc - req_cyc), 32'd3);
               lat_arm = 0;
            end
            if (wr_gap_chk) begin
               check("wr_gap_ge_twr", 32'((cyc - last_wr_done) >= TWR), 32'd1);
               wr_gap_chk = 0;
            end
            if (exp_cmd.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_start: wr=%0b addr=%0d, want no command", bus.i2c_wr, bus.i2c_addr);
            end else begin
               e = exp_cmd.pop_front();
               check("cmd_wr", 32'(bus.i2c_wr), 32'(e.wr));
               check("cmd_addr", 32'(bus.i2c_addr), 32'(e.addr));
               if (e.wr) check("cmd_wdata", 32'(bus.i2c_wdata), 32'(e.wdata));
               check("cmd_dev", 32'(bus.i2c_dev), 32'h50);
            end
         end
         if (bus.result_valid) begin
            n_rv++;
            if (exp_res.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_result: got %h, want no result", bus.result);
            end else begin
               check("result", bus.result, exp_res.pop_front());
            end
         end
         if (bus.ovf)       n_ovf++;
         if (bus.range_err) n_rng++;
         if (bus.ack_err)   n_ack++;
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int b0, b1, b2, b3;
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      set_req(1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 32'h0);

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_result", bus.result, 32'h0);
      check("rst_start", 32'(bus.i2c_start), 32'd0);
      check("rst_dev", 32'(bus.i2c_dev), 32'h50);
      check("rst_flags", 32'({bus.result_valid, bus.ovf, bus.range_err, bus.ack_err}), 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      // 1: single write, key 4
      exp_wr(16'd4, 32'h11223344);
      b0 = n_rv;
      lat_arm = 1;
      req(1'b1, 1'b0, 5'd0, 2'd0, 1'b1, 32'h11223344);
      wait_idle("t1", 3000);
      check("t1_no_result", 32'(n_rv - b0), 32'd0);

      // 2: read back the same key
      exp_rd(16'd4, 4);
      exp_res.push_back(32'h11223344);
      b0 = n_rv;
      req(1'b0, 1'b1, 5'd0, 2'd0, 1'b1, 32'h0);
      wait_idle("t2", 1000);
      check("t2_one_rv", 32'(n_rv - b0), 32'd1);
      check("t2_result_reg", bus.result, 32'h11223344);

      // 3: same-cycle write+read, key 112
      exp_wr(16'd112, 32'h55667788);
      exp_rd(16'd112, 4);
      exp_res.push_back(32'h55667788);
      req(1'b1, 1'b1, 5'd3, 2'd2, 1'b0, 32'h55667788);
      wait_idle("t3", 3000);
      check("t3_result_reg", bus.result, 32'h55667788);

      // 4: one read in flight, then 5 back-to-back reads into a depth-4 queue
      preload(32,  32'hA0A1A2A3);
      preload(76,  32'hB0B1B2B3);
      preload(184, 32'hC0C1C2C3);
      preload(508, 32'hD0D1D2D3);
      preload(228, 32'hE0E1E2E3);
      preload(296, 32'hF0F1F2F3);
      b0 = n_ovf;
      exp_rd(16'd32, 4);  exp_res.push_back(32'hA0A1A2A3);
      req(1'b0, 1'b1, 5'd1, 2'd0, 1'b0, 32'h0);
      for (int i = 0; i < 200 && exp_cmd.size() > 3; i++) @(negedge clk);
      check("t4_inflight", 32'(exp_cmd.size()), 32'd3);
      exp_rd(16'd76, 4);  exp_res.push_back(32'hB0B1B2B3);
      exp_rd(16'd184, 4); exp_res.push_back(32'hC0C1C2C3);
      exp_rd(16'd508, 4); exp_res.push_back(32'hD0D1D2D3);
      exp_rd(16'd228, 4); exp_res.push_back(32'hE0E1E2E3);
      @(posedge clk); #1;
      set_req(1'b0, 1'b1, 5'd2,  2'd1, 1'b1, 32'h0); @(posedge clk); #1;
      set_req(1'b0, 1'b1, 5'd5,  2'd3, 1'b0, 32'h0); @(posedge clk); #1;
      set_req(1'b0, 1'b1, 5'd15, 2'd3, 1'b1, 32'h0); @(posedge clk); #1;
      set_req(1'b0, 1'b1, 5'd7,  2'd0, 1'b1, 32'h0); @(posedge clk); #1;
      set_req(1'b0, 1'b1, 5'd9,  2'd1, 1'b0, 32'h0); @(posedge clk); #1;
      bus.rd_req = 1'b0;
      wait_idle("t4", 5000);
      check("t4_ovf_count", 32'(n_ovf - b0), 32'd1);
      check("t4_result_reg", bus.result, 32'hE0E1E2E3);

      // 5: NACK on byte 2 of a read, followed by a normal read; then an out-of-range channel
      b0 = n_ack; b1 = n_rv;
      nack_addr = 16'd34; nack_arm = 1'b1;
      exp_rd(16'd32, 3);
      exp_rd(16'd76, 4); exp_res.push_back(32'hB0B1B2B3);
      req(1'b0, 1'b1, 5'd1, 2'd0, 1'b0, 32'h0);
      req(1'b0, 1'b1, 5'd2, 2'd1, 1'b1, 32'h0);
      for (int i = 0; i < 500 && n_ack == b0; i++) @(negedge clk);
      check("t5_ack_seen", 32'(n_ack - b0), 32'd1);
      check("t5_result_kept", bus.result, 32'hE0E1E2E3);
      check("t5_no_rv_on_nack", 32'(n_rv - b1), 32'd0);
      wait_idle("t5", 2000);
      check("t5_next_entry", bus.result, 32'hB0B1B2B3);
      check("t5_ack_total", 32'(n_ack - b0), 32'd1);
      b2 = n_rng; b3 = n_ovf;
      req(1'b0, 1'b1, 5'd16, 2'd0, 1'b0, 32'h0);
      repeat (10) @(negedge clk);
      check("t5_range_err", 32'(n_rng - b2), 32'd1);
      check("t5_range_busy", 32'(bus.busy), 32'd0);
      check("t5_range_no_ovf", 32'(n_ovf - b3), 32'd0);

      // 6: reset while waiting out the write delay, then a fresh read
      exp_cmd.push_back('{wr: 1'b1, addr: 16'd8, wdata: 8'hD4});
      req(1'b1, 1'b0, 5'd0, 2'd1, 1'b0, 32'hA1B2C3D4);
      for (int i = 0; i < 200 && !wr_gap_chk; i++) @(negedge clk);
      check("t6_first_write", 32'(wr_gap_chk), 32'd1);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      wr_gap_chk = 0;
      check("t6_busy", 32'(bus.busy), 32'd0);
      check("t6_result", bus.result, 32'h0);
      check("t6_i2c", 32'({bus.i2c_start, bus.i2c_wr, bus.i2c_wdata, bus.i2c_addr}), 32'd0);
      check("t6_flags", 32'({bus.result_valid, bus.ovf, bus.range_err, bus.ack_err}), 32'd0);
      check("t6_dev", 32'(bus.i2c_dev), 32'h50);
      repeat (200) @(negedge clk);
      check("t6_no_resume", 32'(bus.busy), 32'd0);
      exp_rd(16'd8, 4);
      exp_res.push_back(32'h000000D4);
      lat_arm = 1;
      req(1'b0, 1'b1, 5'd0, 2'd1, 1'b0, 32'h0);
      wait_idle("t6", 1000);
      check("t6_result_after", bus.result, 32'h000000D4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
